// File: rtl/clk_mon_pkg.sv
// Purpose: shared types and the period tolerance check for clk_period_monitor.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package clk_mon_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} mon_state_t;

    // True when |period - exp_p| <= tol, all operands unsigned. The magnitude
    // is taken by subtracting the smaller operand from the larger, so the
    // difference can never wrap.
    function automatic logic period_ok(
        input logic [31:0] period,
        input logic [31:0] exp_p,
        input logic [31:0] tol
    );
        logic [31:0] diff;
        diff = (period >= exp_p) ? (period - exp_p) : (exp_p - period);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Purpose: samples an asynchronous-to-us level through SYNC_STAGES flops and flags its rising edge.
// Latency: s_q follows sig by SYNC_STAGES clk edges; rise is combinational from s_q and one more flop.
// Backpressure: none; sig is sampled every cycle.
//
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset
//   sig  - level to sample
//   s_q  - sampled level (last stage of the chain)
//   rise - high for one cycle when s_q goes 0 -> 1
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic s_q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync[0] <= sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            s_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign s_q  = sync[SYNC_STAGES-1];
    assign rise = s_q & ~s_prev;

endmodule

// File: rtl/clk_period_monitor.sv
// Purpose: measures period/high time of a divided clock in i_clk cycles and reports lock, error and timeout.
// Latency: o_valid rises two i_clk edges after the sampled rising edge of i_sig (SYNC_STAGES+2 after i_sig is first sampled high).
// Backpressure: none; every measurement is reported, there is no ready.
//
// Ports:
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_en              - monitor enable; low aborts to IDLE and discards partial measurements
//   i_sig             - divided clock under test, sampled as a plain signal
//   i_err_clr         - clears sticky o_err (a simultaneous new error wins)
//   o_period, o_high  - last measured period / high time
//   o_valid           - one-cycle pulse when o_period/o_high/o_locked update
//   o_locked          - LOCK_COUNT consecutive good periods seen
//   o_err             - sticky: bad period or timeout since last clear
//   o_timeout         - one-cycle pulse: no rising edge within MAX_PERIOD cycles
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD  = 15,
    parameter int TOL         = 0,
    parameter int MAX_PERIOD  = 64,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = $clog2(MAX_PERIOD + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sig,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_timeout
);

    localparam int               LK_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_COUNT);

    mon_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [LK_W-1:0]  lock_cnt;
    logic [LK_W-1:0]  lock_nxt;
    logic             meas_pend;   // o_period/o_high were captured last edge; check them now
    logic             s_q;
    logic             rise;
    logic             good;
    logic             bad_meas;
    logic             timeout_hit;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .sig  (i_sig),
        .s_q  (s_q),
        .rise (rise)
    );

    // The check runs on the registered o_period one cycle after capture, so
    // o_valid, o_locked and a new o_err all change on the same edge.
    always_comb begin
        good        = period_ok(32'(o_period), 32'(EXP_PERIOD), 32'(TOL));
        lock_nxt    = '0;
        if (good) begin
            lock_nxt = (lock_cnt == LK_MAX) ? lock_cnt : lock_cnt + LK_W'(1);
        end
        bad_meas    = meas_pend & i_en & ~good;
        timeout_hit = i_en & (state == MEAS) & ~rise & (cnt == CNT_MAX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            lock_cnt  <= '0;
            meas_pend <= 1'b0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            meas_pend <= 1'b0;

            // Setting has priority over clearing.
            if (bad_meas || timeout_hit) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end

            if (!i_en) begin
                state    <= IDLE;
                cnt      <= '0;
                hcnt     <= '0;
                lock_cnt <= '0;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM: begin
                        // First edge only starts the count; nothing to report yet.
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            o_period  <= cnt;
                            o_high    <= hcnt;
                            meas_pend <= 1'b1;
                            cnt       <= CNT_ONE;
                            hcnt      <= CNT_ONE;
                        end else if (cnt == CNT_MAX) begin
                            o_timeout <= 1'b1;
                            lock_cnt  <= '0;
                            o_locked  <= 1'b0;
                            cnt       <= '0;
                            hcnt      <= '0;
                            state     <= ARM;
                        end else begin
                            // cnt < CNT_MAX here and hcnt <= cnt, so neither can wrap.
                            cnt <= cnt + CNT_ONE;
                            if (s_q) begin
                                hcnt <= hcnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                if (meas_pend) begin
                    o_valid  <= 1'b1;
                    lock_cnt <= lock_nxt;
                    o_locked <= (lock_nxt == LK_MAX);
                end
            end
        end
    end

endmodule
